// File: rtl/delay_ctrl_pkg.sv
// rtl/delay_ctrl_pkg.sv - shared types, index constants and cycle helpers for the delay bank
package delay_ctrl_pkg;

  // Per-button auto-repeat state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } btn_state_t;

  // Button/register index = colour*NUM_KINDS + kind.
  localparam int COLOR_R      = 0;
  localparam int COLOR_G      = 1;
  localparam int COLOR_B      = 2;
  localparam int NUM_COLORS   = 3;
  localparam int KIND_WHOLE   = 0;
  localparam int KIND_RISING  = 1;
  localparam int KIND_FALLING = 2;
  localparam int NUM_KINDS    = 3;

  function automatic int btn_index(input int color, input int kind);
    return color * NUM_KINDS + kind;
  endfunction

  // Converts a duration in ns into whole clock cycles.
  function automatic int ns_to_cycles(input int dur_ns, input int clk_period_ns);
    return dur_ns / clk_period_ns;
  endfunction

endpackage

// File: rtl/delay_ctrl_bank_if.sv
// rtl/delay_ctrl_bank_if.sv - button/switch inputs and delay/LED outputs of the delay bank
// Signals: inverse (step direction), btn (raw buttons), delay_value (packed registers),
// step_pulse (per-register step strobe), LED_OUTPUT (low bits of last-stepped register).
interface delay_ctrl_bank_if #(
  parameter int NUM_BTN = 9,
  parameter int DELAY_W = 4
);
  logic                         inverse;
  logic [NUM_BTN-1:0]           btn;
  logic [NUM_BTN*DELAY_W-1:0]   delay_value;
  logic [NUM_BTN-1:0]           step_pulse;
  logic [3:0]                   LED_OUTPUT;

  modport master (
    output inverse, btn,
    input  delay_value, step_pulse, LED_OUTPUT
  );

  modport slave (
    input  inverse, btn,
    output delay_value, step_pulse, LED_OUTPUT
  );
endinterface

// File: rtl/btn_debounce_repeat.sv
// rtl/btn_debounce_repeat.sv - one button: 2-FF sync, debounce counter, hold-to-repeat FSM
// Ports: clk_x10 (clock), g_rst (async active-low reset), btn (raw button),
// step_pulse (registered one-cycle step request).
module btn_debounce_repeat
  import delay_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC     = 4_000_000,
  parameter int REPEAT_DELAY_CYC = 100_000_000,
  parameter int REPEAT_RATE_CYC  = 20_000_000
) (
  input  logic clk_x10,
  input  logic g_rst,
  input  logic btn,
  output logic step_pulse
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int TMR_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [TMR_W-1:0] DELAY_LOAD = TMR_W'(REPEAT_DELAY_CYC);
  localparam logic [TMR_W-1:0] RATE_LOAD  = TMR_W'(REPEAT_RATE_CYC);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
  localparam bit               REPEAT_EN  = (REPEAT_DELAY_CYC != 0);

  logic [1:0]       sync_q;
  logic             deb_q;
  logic [CNT_W-1:0] cnt_q;

  // Counter only runs while the synced level disagrees with the accepted state,
  // so any glitch back to the accepted level restarts the stability window.
  always_ff @(posedge clk_x10 or negedge g_rst) begin
    if (!g_rst) begin
      sync_q <= '0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], btn};
      if (sync_q[1] == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        deb_q <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  btn_state_t       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             step_q, step_d;

  // Timer expires when it reads 1, so a load of N yields the next step N cycles later.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    step_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (deb_q) begin
          state_d = DELAY;
          step_d  = 1'b1;
          tmr_d   = DELAY_LOAD;
        end
      end
      DELAY: begin
        if (!deb_q) begin
          state_d = IDLE;
        end else if (REPEAT_EN && tmr_q == TMR_ONE) begin
          state_d = REPEAT;
          step_d  = 1'b1;
          tmr_d   = RATE_LOAD;
        end else if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      REPEAT: begin
        if (!deb_q) begin
          state_d = IDLE;
        end else if (tmr_q == TMR_ONE) begin
          step_d = 1'b1;
          tmr_d  = RATE_LOAD;
        end else if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_x10 or negedge g_rst) begin
    if (!g_rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      step_q  <= step_d;
    end
  end

  assign step_pulse = step_q;

endmodule

// File: rtl/delay_ctrl_bank.sv
// rtl/delay_ctrl_bank.sv - bank of button-stepped delay registers with wrap/saturate and LED readback
// Ports: clk_x10 (clock), g_rst (async active-low reset), bus (slave side of
// delay_ctrl_bank_if: inverse/btn in; delay_value/step_pulse/LED_OUTPUT out).
module delay_ctrl_bank
  import delay_ctrl_pkg::*;
#(
  parameter int CLK_PERIOD       = 5,
  parameter int NUM_BTN          = NUM_COLORS * NUM_KINDS,
  parameter int DELAY_W          = 4,
  parameter int INIT_VALUE       = 0,
  parameter bit SATURATE         = 1'b0,
  parameter int DEBOUNCE_CYC     = ns_to_cycles(20_000_000, CLK_PERIOD),
  parameter int REPEAT_DELAY_CYC = ns_to_cycles(500_000_000, CLK_PERIOD),
  parameter int REPEAT_RATE_CYC  = ns_to_cycles(100_000_000, CLK_PERIOD)
) (
  input logic               clk_x10,
  input logic               g_rst,
  delay_ctrl_bank_if.slave  bus
);

  localparam int IDX_W = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
  localparam logic [DELAY_W-1:0] MAX_V  = '1;
  localparam logic [DELAY_W-1:0] INIT_V = DELAY_W'(INIT_VALUE);

  logic [NUM_BTN-1:0] step;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce_repeat #(
      .DEBOUNCE_CYC     (DEBOUNCE_CYC),
      .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
      .REPEAT_RATE_CYC  (REPEAT_RATE_CYC)
    ) u_btn (
      .clk_x10    (clk_x10),
      .g_rst      (g_rst),
      .btn        (bus.btn[g]),
      .step_pulse (step[g])
    );
  end

  function automatic logic [DELAY_W-1:0] next_val(input logic [DELAY_W-1:0] v, input logic dec);
    if (!dec) return (v == MAX_V) ? (SATURATE ? v : '0) : v + 1'b1;
    else      return (v == '0)    ? (SATURATE ? v : MAX_V) : v - 1'b1;
  endfunction

  logic [1:0]         inv_sync_q;
  logic [DELAY_W-1:0] val_q [NUM_BTN];
  logic [IDX_W-1:0]   led_idx_q;
  logic [IDX_W-1:0]   led_sel;
  logic               led_hit;

  // Descending scan so the lowest simultaneously-stepped index ends up selected.
  always_comb begin
    led_sel = '0;
    led_hit = 1'b0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (step[i]) begin
        led_hit = 1'b1;
        led_sel = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk_x10 or negedge g_rst) begin
    if (!g_rst) begin
      inv_sync_q <= '0;
      led_idx_q  <= '0;
      for (int i = 0; i < NUM_BTN; i++) val_q[i] <= INIT_V;
    end else begin
      inv_sync_q <= {inv_sync_q[0], bus.inverse};
      for (int i = 0; i < NUM_BTN; i++) begin
        if (step[i]) val_q[i] <= next_val(val_q[i], inv_sync_q[1]);
      end
      if (led_hit) led_idx_q <= led_sel;
    end
  end

  logic [NUM_BTN*DELAY_W-1:0] packed_val;
  always_comb begin
    packed_val = '0;
    for (int i = 0; i < NUM_BTN; i++) packed_val[i*DELAY_W +: DELAY_W] = val_q[i];
  end

  logic [DELAY_W-1:0] led_val;
  assign led_val = val_q[led_idx_q];

  if (DELAY_W >= 4) begin : g_led_trunc
    assign bus.LED_OUTPUT = led_val[3:0];
  end else begin : g_led_ext
    assign bus.LED_OUTPUT = 4'(led_val);
  end

  assign bus.delay_value = packed_val;
  assign bus.step_pulse  = step;

endmodule

// File: tb/tb_delay_ctrl_bank.sv
// tb/tb_delay_ctrl_bank.sv - scoreboard bench for delay_ctrl_bank (wrap and saturate instances)
module tb_delay_ctrl_bank;

  localparam int NB  = 9;
  localparam int DW  = 4;
  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RR  = 5;
  localparam int MAXV = (1 << DW) - 1;

  typedef struct {
    int t;
    int v;
  } exp_t;

  logic clk_x10 = 1'b0;
  logic g_rst   = 1'b0;
  logic [NB-1:0] btn_v = '0;
  logic inv_v = 1'b0;
  int cyc = 0;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_x10 = ~clk_x10;
  always @(posedge clk_x10) cyc <= cyc + 1;

  delay_ctrl_bank_if #(.NUM_BTN(NB), .DELAY_W(DW)) if0 ();
  delay_ctrl_bank_if #(.NUM_BTN(NB), .DELAY_W(DW)) if1 ();

  assign if0.btn = btn_v;
  assign if1.btn = btn_v;
  assign if0.inverse = inv_v;
  assign if1.inverse = inv_v;

  delay_ctrl_bank #(
    .NUM_BTN(NB), .DELAY_W(DW), .INIT_VALUE(14), .SATURATE(1'b0),
    .DEBOUNCE_CYC(DEB), .REPEAT_DELAY_CYC(RD), .REPEAT_RATE_CYC(RR)
  ) dut0 (.clk_x10(clk_x10), .g_rst(g_rst), .bus(if0));

  delay_ctrl_bank #(
    .NUM_BTN(NB), .DELAY_W(DW), .INIT_VALUE(1), .SATURATE(1'b1),
    .DEBOUNCE_CYC(DEB), .REPEAT_DELAY_CYC(RD), .REPEAT_RATE_CYC(RR)
  ) dut1 (.clk_x10(clk_x10), .g_rst(g_rst), .bus(if1));

  logic [NB*DW-1:0] dv  [2];
  logic [NB-1:0]    sp  [2];
  logic [3:0]       led [2];
  assign dv[0] = if0.delay_value;  assign dv[1] = if1.delay_value;
  assign sp[0] = if0.step_pulse;   assign sp[1] = if1.step_pulse;
  assign led[0] = if0.LED_OUTPUT;  assign led[1] = if1.LED_OUTPUT;

  function automatic int init_of(input int d);
    return (d == 0) ? 14 : 1;
  endfunction

  function automatic bit sat_of(input int d);
    return d == 1;
  endfunction

  // Reference step rule: +/-1 modulo 2^DW, or clamped to [0, MAXV].
  function automatic int step_val(input int v, input bit dec, input bit sat);
    int n;
    n = dec ? v - 1 : v + 1;
    if (sat) return (n < 0) ? 0 : (n > MAXV) ? MAXV : n;
    return (n + MAXV + 1) % (MAXV + 1);
  endfunction

  exp_t q [2][NB][$];
  int   mval [2][NB];
  bit   pend [2][NB];
  int   pend_v [2][NB];
  bit   led_pend [2];
  int   led_exp [2];

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_x10);
    #1;
  endtask

  // A button held stable for len samples from cycle s is accepted after DEB samples;
  // it steps at s+DEB+3, then RD later, then every RR, while held (offset <= len-1).
  task automatic push_hold(input int b, input int s, input int len, input bit dec);
    int off;
    exp_t e;
    if (len < DEB) return;
    off = 0;
    while (off <= len - 1) begin
      for (int d = 0; d < 2; d++) begin
        mval[d][b] = step_val(mval[d][b], dec, sat_of(d));
        e.t = s + DEB + 3 + off;
        e.v = mval[d][b];
        q[d][b].push_back(e);
      end
      if (off == 0) begin
        if (RD == 0) break;
        off = RD;
      end else begin
        off += RR;
      end
    end
  endtask

  task automatic episode(input logic [NB-1:0] mask, input int lens [NB], input bit dec, input int nbounce);
    int s;
    int lmax;
    inv_v = dec;
    repeat (4) tick();
    for (int k = 0; k < nbounce; k++) begin
      btn_v = mask;
      repeat ($urandom_range(1, DEB - 1)) tick();
      btn_v = '0;
      repeat ($urandom_range(1, DEB - 1)) tick();
    end
    btn_v = mask;
    s = cyc;
    lmax = 0;
    for (int b = 0; b < NB; b++) begin
      if (mask[b]) begin
        push_hold(b, s, lens[b], dec);
        if (lens[b] > lmax) lmax = lens[b];
      end
    end
    for (int k = 1; k <= lmax; k++) begin
      tick();
      for (int b = 0; b < NB; b++) if (mask[b] && lens[b] == k) btn_v[b] = 1'b0;
    end
    repeat (DEB + 10) tick();
  endtask

  task automatic check_vals(input string tag);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NB; i++)
        chk($sformatf("%s_val d%0d i%0d", tag, d, i), int'(dv[d][i*DW +: DW]), mval[d][i]);
  endtask

  task automatic flush_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NB; i++) begin
        q[d][i].delete();
        mval[d][i] = init_of(d);
      end
  endtask

  // Monitor: pops the scoreboard whenever a DUT pulses, and checks the register and
  // LED one cycle later against the values the model attached to that step.
  always @(negedge clk_x10) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (!g_rst) begin
        led_pend[d] = 1'b0;
        for (int i = 0; i < NB; i++) pend[d][i] = 1'b0;
        chk($sformatf("rst_step d%0d", d), int'(sp[d]), 0);
        chk($sformatf("rst_led d%0d", d), int'(led[d]), init_of(d) & 15);
        for (int i = 0; i < NB; i++)
          chk($sformatf("rst_val d%0d i%0d", d, i), int'(dv[d][i*DW +: DW]), init_of(d));
      end else begin
        for (int i = 0; i < NB; i++) begin
          if (pend[d][i]) begin
            chk($sformatf("step_val d%0d i%0d", d, i), int'(dv[d][i*DW +: DW]), pend_v[d][i]);
            pend[d][i] = 1'b0;
          end
        end
        if (led_pend[d]) begin
          chk($sformatf("led d%0d", d), int'(led[d]), led_exp[d] & 15);
          led_pend[d] = 1'b0;
        end
        for (int i = NB - 1; i >= 0; i--) begin
          if (sp[d][i]) begin
            chk($sformatf("step_queued d%0d i%0d", d, i), int'(q[d][i].size() > 0), 1);
            if (q[d][i].size() > 0) begin
              e = q[d][i].pop_front();
              chk($sformatf("step_cycle d%0d i%0d", d, i), cyc, e.t);
              pend[d][i]   = 1'b1;
              pend_v[d][i] = e.v;
              led_pend[d]  = 1'b1;
              led_exp[d]   = e.v;
            end
          end else if (q[d][i].size() > 0 && q[d][i][0].t <= cyc) begin
            chk($sformatf("step_pulse d%0d i%0d", d, i), int'(sp[d][i]), 1);
            void'(q[d][i].pop_front());
          end
        end
      end
    end
  end

  initial begin
    int lens [NB];
    int s3;
    int r;
    logic [NB-1:0] mask;

    flush_model();
    g_rst = 1'b0;
    repeat (3) tick();
    g_rst = 1'b1;
    repeat (3) tick();
    check_vals("reset");

    for (int b = 0; b < NB; b++) lens[b] = 10;
    episode(9'b0_0000_0001, lens, 1'b0, 0);
    check_vals("single");

    for (int k = 0; k < 15; k++) begin
      btn_v[4] = ~btn_v[4];
      repeat (2) tick();
    end
    btn_v[4] = 1'b0;
    repeat (DEB + 10) tick();
    check_vals("bounce");

    lens[1] = 60;
    episode(9'b0_0000_0010, lens, 1'b0, 0);
    check_vals("repeat_up");
    lens[1] = 120;
    episode(9'b0_0000_0010, lens, 1'b1, 1);
    check_vals("repeat_down");

    lens[2] = 10;
    lens[7] = 10;
    episode(9'b0_1000_0100, lens, 1'b0, 0);
    check_vals("simul");

    for (int n = 0; n < 12; n++) begin
      mask = NB'($urandom_range(1, (1 << NB) - 1));
      for (int b = 0; b < NB; b++) lens[b] = $urandom_range(1, 45);
      episode(mask, lens, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      check_vals($sformatf("rand%0d", n));
    end

    inv_v = 1'b0;
    repeat (4) tick();
    btn_v[3] = 1'b1;
    s3 = cyc;
    push_hold(3, s3, 100, 1'b0);
    while (cyc < s3 + DEB + 3 + RD + RR + 2) tick();
    g_rst = 1'b0;
    flush_model();
    repeat (3) tick();
    g_rst = 1'b1;
    r = cyc;
    push_hold(3, r, 30, 1'b0);
    repeat (30) tick();
    btn_v[3] = 1'b0;
    repeat (DEB + 10) tick();
    check_vals("post_reset");

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NB; i++)
        chk($sformatf("leftover d%0d i%0d", d, i), q[d][i].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/delay_ctrl_bank.md
# delay_ctrl_bank

Parametrised button-driven delay-setting bank for the PAM4-RGB transmitter. It replaces the fixed 9-button / 4-bit control with NUM_BTN independent delay registers of DELAY_W bits. Each register has its own debouncer with hold-to-auto-repeat, and a selectable wrap or saturate mode. It sits between the board push-buttons/DIP switch and the per-colour whole/rising/falling delay lines, and drives the 4 status LEDs.

## Interface
- CLK_PERIOD, 5: clock period in ns (200 MHz); informational, used only for default cycle counts.
- NUM_BTN, 9: number of buttons and delay registers (index = colour*3 + {whole, rising, falling}).
- DELAY_W, 4: width of each delay register.
- INIT_VALUE, 0: reset value of every register.
- SATURATE, 0: 0 = modular wrap, 1 = clamp at 0 / 2^DELAY_W-1.
- DEBOUNCE_CYC, 4_000_000: consecutive stable cycles required to accept a level change (20 ms).
- REPEAT_DELAY_CYC, 100_000_000: hold time before the first auto-repeat step (0.5 s); 0 disables auto-repeat.
- REPEAT_RATE_CYC, 20_000_000: auto-repeat period (100 ms); must be ≥1.
- clk_x10  in  1  system clock, all logic rising-edge.
- g_rst  in  1  asynchronous, active-low reset.
- inverse  in  1  step direction: 0 = increment, 1 = decrement; asynchronous, synchronised internally.
- btn  in  NUM_BTN  raw active-high buttons, asynchronous.
- delay_value  out  NUM_BTN*DELAY_W  register i at bits [i*DELAY_W +: DELAY_W].
- step_pulse  out  NUM_BTN  one-cycle pulse when register i is stepped.
- LED_OUTPUT  out  4  low 4 bits of the last-stepped register, zero-extended if DELAY_W<4.

## Operation
- Per button: 2-FF synchroniser, then debounce counter. The counter runs while the synced level differs from the debounced state; any agreement resets it to 0. The state flips when the counter reaches DEBOUNCE_CYC-1.
- Per-button FSM:
  - IDLE: on debounced press, go to DELAY, emit a step, and load the timer with REPEAT_DELAY_CYC.
  - DELAY: on release, go to IDLE. On timer expiry, go to REPEAT, emit a step, and load REPEAT_RATE_CYC.
  - REPEAT: on expiry, emit a step and reload. On release, go to IDLE.
  - If REPEAT_DELAY_CYC=0, the FSM stays in DELAY until release.
- Step: register ±1 using the synced `inverse` as sampled in the step cycle.
  - SATURATE=0: 2^DELAY_W-1 +1 → 0 and 0 −1 → 2^DELAY_W-1.
  - SATURATE=1: the value holds at the limit. step_pulse still fires.
- Registers are independent; simultaneous steps on several indices all apply in the same cycle.
- LED source index is latched on every step. On simultaneous steps, the lowest index wins.
- Reset (any time, including mid-hold or mid-debounce):
  - All FSMs go to IDLE; synchronisers, debounced states and counters go to 0.
  - Registers go to INIT_VALUE; step_pulse goes to 0; LED index goes to 0.
  - LED_OUTPUT = low bits of INIT_VALUE.
  - A button held through reset release is seen as a new press after debounce.

## Timing
- Raw btn rising (stable) → step_pulse high at cycle 2+DEBOUNCE_CYC+1 → delay_value/LED_OUTPUT updated at the following edge. Total latency is DEBOUNCE_CYC+4 cycles.
- Release latency is 2+DEBOUNCE_CYC cycles; no step on release.
- Auto-repeat pulses occur REPEAT_DELAY_CYC after the first step, then every REPEAT_RATE_CYC, exact to the cycle.
- `inverse` is synchronised through 2 FFs; a change takes effect on steps ≥3 cycles later.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package delay_ctrl_pkg:
  - FSM state enum {IDLE, DELAY, REPEAT}.
  - Index constants for colour {R, G, B} and kind {WHOLE, RISING, FALLING}.
  - Function computing cycle counts from CLK_PERIOD.
- Sub-module btn_debounce_repeat (synchroniser, debounce counter, FSM, timer; outputs step pulse), instantiated NUM_BTN times via generate.
- Top holds the value registers, LED index latch and LED mux. Counter widths come from $clog2 of the cycle parameters.

## Test plan
All scenarios use DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=20, REPEAT_RATE_CYC=5, DELAY_W=4.
- Reset released, no input → all delay_value=0, LED_OUTPUT=0, step_pulse=0.
- btn[0] high, stable, for 10 cycles then low:
  - step_pulse[0] at cycle 7; value[0]=1 at cycle 8; LED_OUTPUT=1.
  - No further change.
- btn[4] toggles every 2 cycles for 30 cycles (bounce) → no step_pulse, value[4] stays 0.
- btn[1] held 60 cycles, inverse=0, INIT_VALUE=14:
  - Steps at cycles 7, 27, 32, 37, …
  - Values go 15, 0, 1, … (wrap).
  - Repeat with SATURATE=1 and inverse=1, INIT_VALUE=1: values 0, 0, 0, step_pulse still pulsing.
- btn[2] and btn[7] pressed in the same cycle → both values +1 in the same cycle; LED_OUTPUT shows register 2.
- g_rst asserted during btn[3] REPEAT phase, released with btn[3] still held:
  - All values reset to INIT_VALUE.
  - A new first step arrives DEBOUNCE_CYC+3 cycles after reset release.
